// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the pipeline stage buffers: reset PC, default field
// widths and the exception codes carried between stages.
package pipe_stage_buf_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          EXC_W_DEFAULT    = 5;
  localparam int          DATA_W_DEFAULT   = 64;

  // Exception codes; EXC_NONE marks an instruction with nothing raised.
  localparam logic [EXC_W_DEFAULT-1:0] EXC_NONE = 5'd0;
  localparam logic [EXC_W_DEFAULT-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W_DEFAULT-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W_DEFAULT-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W_DEFAULT-1:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Upstream and downstream links of one pipeline stage buffer.
interface pipe_stage_buf_if
  import pipe_stage_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int EXC_W  = EXC_W_DEFAULT
);

  // Handshake: a beat transfers on a rising clk edge where valid && ready are
  // both high; valid never waits on ready, and the sender holds its fields
  // only as long as it wants the beat offered.
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [31:0]       in_instr;
  logic [DATA_W-1:0] in_data;
  logic [EXC_W-1:0]  in_exc;
  logic              in_bd;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_instr;
  logic [DATA_W-1:0] out_data;
  logic [EXC_W-1:0]  out_exc;
  logic              out_bd;

  modport master (
    output in_valid, in_pc, in_instr, in_data, in_exc, in_bd, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_data, out_exc, out_bd
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_data, in_exc, in_bd, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_data, out_exc, out_bd
  );

endinterface

// File: rtl/pipe_stage_buf_entry.sv
// One buffer entry {pc, instr, data, exc, bd} with load and bubble clear.
// A bubble zeroes instr/exc/bd but keeps pc and data as last loaded.
module pipe_entry_reg
  import pipe_stage_buf_pkg::*;
#(
  parameter int          DATA_W   = DATA_W_DEFAULT,
  parameter int          EXC_W    = EXC_W_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [31:0]       d_pc,
  input  logic [31:0]       d_instr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [EXC_W-1:0]  d_exc,
  input  logic              d_bd,
  output logic              q_valid,
  output logic [31:0]       q_pc,
  output logic [31:0]       q_instr,
  output logic [DATA_W-1:0] q_data,
  output logic [EXC_W-1:0]  q_exc,
  output logic              q_bd
);

  // Clear wins over load so a flush also drops a same-cycle load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_pc    <= RESET_PC;
      q_instr <= '0;
      q_data  <= '0;
      q_exc   <= '0;
      q_bd    <= 1'b0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_instr <= '0;
      q_exc   <= '0;
      q_bd    <= 1'b0;
    end else if (load) begin
      q_valid <= 1'b1;
      q_pc    <= d_pc;
      q_instr <= d_instr;
      q_data  <= d_data;
      q_exc   <= d_exc;
      q_bd    <= d_bd;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: main entry drives the outputs, optional skid
// entry absorbs one beat so in_ready can come straight from a flop.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int          DATA_W   = DATA_W_DEFAULT,
  parameter int          EXC_W    = EXC_W_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          SKID     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  pipe_stage_buf_if.slave bus,
  output logic [1:0]      occupancy,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e state_q, state_d;
  logic   in_ready_w, accept, drain;
  logic   main_load, main_clear, main_from_skid, skid_load, skid_clear;

  logic              main_valid, main_bd, skid_valid, skid_bd;
  logic [31:0]       main_pc, main_instr, skid_pc, skid_instr;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [EXC_W-1:0]  main_exc, skid_exc;

  assign accept = bus.in_valid && in_ready_w;
  assign drain  = main_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
        ONE: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (drain) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        TWO: if (drain) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_d        = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Without a skid entry ONE can only accept while draining, so TWO is never
  // reached and the same state machine serves both variants.
  if (SKID != 0) begin : g_skid
    logic in_ready_q;
    always_ff @(posedge clk) begin
      if (reset) in_ready_q <= 1'b1;
      else       in_ready_q <= (state_d != TWO);
    end
    assign in_ready_w = in_ready_q;
  end else begin : g_noskid
    assign in_ready_w = !main_valid || bus.out_ready;
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .RESET_PC(RESET_PC)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .d_pc    (main_from_skid ? skid_pc    : bus.in_pc),
    .d_instr (main_from_skid ? skid_instr : bus.in_instr),
    .d_data  (main_from_skid ? skid_data  : bus.in_data),
    .d_exc   (main_from_skid ? skid_exc   : bus.in_exc),
    .d_bd    (main_from_skid ? skid_bd    : bus.in_bd),
    .q_valid (main_valid),
    .q_pc    (main_pc),
    .q_instr (main_instr),
    .q_data  (main_data),
    .q_exc   (main_exc),
    .q_bd    (main_bd)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .RESET_PC(RESET_PC)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_pc    (bus.in_pc),
    .d_instr (bus.in_instr),
    .d_data  (bus.in_data),
    .d_exc   (bus.in_exc),
    .d_bd    (bus.in_bd),
    .q_valid (skid_valid),
    .q_pc    (skid_pc),
    .q_instr (skid_instr),
    .q_data  (skid_data),
    .q_exc   (skid_exc),
    .q_bd    (skid_bd)
  );

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = main_valid;
  assign bus.out_pc    = main_pc;
  assign bus.out_instr = main_instr;
  assign bus.out_data  = main_data;
  assign bus.out_exc   = main_exc;
  assign bus.out_bd    = main_bd;
  assign occupancy     = {1'b0, main_valid} + {1'b0, skid_valid};
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a SKID=1 and a SKID=0 copy share one stimulus
// stream and are each checked every cycle against a queue model.
module tb_pipe_stage_buf;

  localparam int W = 134;  // {pc, instr, data[63:0], exc[4:0], bd}
  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset, flush;
  logic t_valid, t_ordy, t_bd;
  logic [31:0] t_pc, t_instr;
  logic [63:0] t_data;
  logic [4:0]  t_exc;
  logic [1:0]  occ1, occ0, st1, st0;
  logic        chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q [2][$];
  logic [31:0]  last_pc [2];
  logic [63:0]  last_data [2];

  pipe_stage_buf_if #(.DATA_W(64), .EXC_W(5)) if1 ();
  pipe_stage_buf_if #(.DATA_W(64), .EXC_W(5)) if0 ();

  assign if1.in_valid = t_valid;  assign if0.in_valid = t_valid;
  assign if1.in_pc    = t_pc;     assign if0.in_pc    = t_pc;
  assign if1.in_instr = t_instr;  assign if0.in_instr = t_instr;
  assign if1.in_data  = t_data;   assign if0.in_data  = t_data;
  assign if1.in_exc   = t_exc;    assign if0.in_exc   = t_exc;
  assign if1.in_bd    = t_bd;     assign if0.in_bd    = t_bd;
  assign if1.out_ready = t_ordy;  assign if0.out_ready = t_ordy;

  pipe_stage_buf #(.DATA_W(64), .EXC_W(5), .RESET_PC(RST_PC), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if1), .occupancy(occ1), .state_dbg(st1)
  );
  pipe_stage_buf #(.DATA_W(64), .EXC_W(5), .RESET_PC(RST_PC), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .bus(if0), .occupancy(occ0), .state_dbg(st0)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
    t_valid = v;
    t_pc    = pc;
    t_instr = pc ^ 32'h0400_0000;
    t_data  = {pc, ~pc};
    t_exc   = 5'd0;
    t_bd    = 1'b0;
    t_ordy  = ordy;
    flush   = fl;
  endtask

  // Scoreboard: a FIFO of capacity 2 (skid) or 1 (no skid)
  function automatic logic model_ready(input int d, input int n);
    if (d == 0) return (n < 2);
    return (n == 0) || t_ordy;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        exp_q[d].delete();
        last_pc[d]   = RST_PC;
        last_data[d] = 64'd0;
      end else if (flush) begin
        exp_q[d].delete();
      end else begin
        int n;
        logic rdy;
        n   = exp_q[d].size();
        rdy = model_ready(d, n);
        if (n > 0 && t_ordy) void'(exp_q[d].pop_front());
        if (t_valid && rdy) exp_q[d].push_back({t_pc, t_instr, t_data, t_exc, t_bd});
        if (exp_q[d].size() > 0) begin
          last_pc[d]   = exp_q[d][0][133:102];
          last_data[d] = exp_q[d][0][69:6];
        end
      end
    end
  end

  task automatic cmp(input int d, input logic v, input logic r, input logic [1:0] occ,
                     input logic [1:0] st, input logic [31:0] pc, input logic [31:0] instr,
                     input logic [63:0] data, input logic [4:0] exc, input logic bd);
    int n;
    logic [W-1:0] h;
    logic ev;
    n  = exp_q[d].size();
    ev = (n > 0);
    h  = ev ? exp_q[d][0] : '0;
    chk($sformatf("d%0d_out_valid", d), 64'(v), 64'(ev));
    chk($sformatf("d%0d_in_ready", d), 64'(r), 64'(model_ready(d, n)));
    chk($sformatf("d%0d_occupancy", d), 64'(occ), 64'(n));
    chk($sformatf("d%0d_state_legal", d), 64'(st == 2'd3), 64'd0);
    chk($sformatf("d%0d_out_pc", d), 64'(pc), 64'(ev ? h[133:102] : last_pc[d]));
    chk($sformatf("d%0d_out_instr", d), 64'(instr), 64'(h[101:70]));
    chk($sformatf("d%0d_out_data", d), data, ev ? h[69:6] : last_data[d]);
    chk($sformatf("d%0d_out_exc", d), 64'(exc), 64'(h[5:1]));
    chk($sformatf("d%0d_out_bd", d), 64'(bd), 64'(h[0]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, if1.out_valid, if1.in_ready, occ1, st1, if1.out_pc, if1.out_instr,
          if1.out_data, if1.out_exc, if1.out_bd);
      cmp(1, if0.out_valid, if0.in_ready, occ0, st0, if0.out_pc, if0.out_instr,
          if0.out_data, if0.out_exc, if0.out_bd);
    end
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    repeat (2) tick();
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("rst_out_valid", 64'(if1.out_valid), 64'd0);
    chk("rst_out_pc", 64'(if1.out_pc), 64'h3000);
    chk("rst_out_instr", 64'(if1.out_instr), 64'd0);
    chk("rst_occupancy", 64'(occ1), 64'd0);
    chk("rst_in_ready", 64'(if1.in_ready), 64'd1);

    // Back-to-back streaming
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 1'b0);
      tick();
      chk($sformatf("stream_pc%0d", i), 64'(if1.out_pc), 64'h3000 + 64'(4 * i));
      chk($sformatf("stream_occ%0d", i), 64'(occ1), 64'd1);
    end
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick();

    // Stall fill then release
    drive(1'b1, 32'h3000, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h3004, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    chk("fill_occ", 64'(occ1), 64'd2);
    chk("fill_in_ready", 64'(if1.in_ready), 64'd0);
    chk("fill_pc", 64'(if1.out_pc), 64'h3000);
    tick();
    chk("stall_pc_stable", 64'(if1.out_pc), 64'h3000);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    chk("drain1_pc", 64'(if1.out_pc), 64'h3004);
    chk("drain1_in_ready", 64'(if1.in_ready), 64'd1);
    tick();
    chk("drain2_valid", 64'(if1.out_valid), 64'd0);
    chk("drain2_pc_held", 64'(if1.out_pc), 64'h3004);

    // Flush in TWO with a competing input
    drive(1'b1, 32'h3020, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h3024, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h3010, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    chk("flush_valid", 64'(if1.out_valid), 64'd0);
    chk("flush_instr", 64'(if1.out_instr), 64'd0);
    chk("flush_occ", 64'(occ1), 64'd0);
    chk("flush_pc_held", 64'(if1.out_pc), 64'h3020);
    tick();
    chk("flush_no_3010", 64'(if1.out_valid), 64'd0);

    // Flush in ONE discards the same-cycle accept
    drive(1'b1, 32'h3050, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h3054, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick();
    chk("flush1_valid", 64'(if1.out_valid), 64'd0);
    chk("flush1_pc", 64'(if1.out_pc), 64'h3050);

    // Exception and delay-slot passthrough
    drive(1'b1, 32'h3030, 1'b1, 1'b0);
    t_instr = 32'h8C01_0000;
    t_exc   = 5'd4;
    t_bd    = 1'b1;
    tick();
    chk("exc_code", 64'(if1.out_exc), 64'd4);
    chk("exc_bd", 64'(if1.out_bd), 64'd1);
    chk("exc_instr", 64'(if1.out_instr), 64'h8C01_0000);
    drive(1'b1, 32'h3034, 1'b1, 1'b0);
    tick();
    chk("exc_next_code", 64'(if1.out_exc), 64'd0);
    chk("exc_next_bd", 64'(if1.out_bd), 64'd0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    tick();

    // SKID=0: ready follows out_ready within the cycle
    drive(1'b1, 32'h3040, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h3044, 1'b0, 1'b0);
    @(negedge clk);
    chk("s0_ready_stall", 64'(if0.in_ready), 64'd0);
    chk("s0_pc_held", 64'(if0.out_pc), 64'h3040);
    #1 t_ordy = 1'b1;
    #1 chk("s0_ready_comb", 64'(if0.in_ready), 64'd1);
    tick();
    chk("s0_new_pc", 64'(if0.out_pc), 64'h3044);
    chk("s0_occ", 64'(occ0), 64'd1);

    // Randomized traffic with occasional flush and reset
    repeat (1500) begin
      reset   = ($urandom_range(0, 99) == 0);
      flush   = ($urandom_range(0, 19) == 0);
      t_valid = ($urandom_range(0, 2) != 0);
      t_ordy  = ($urandom_range(0, 2) != 0);
      t_pc    = $urandom() & 32'hFFFF_FFFC;
      t_instr = $urandom();
      t_data  = {$urandom(), $urandom()};
      t_exc   = 5'($urandom_range(0, 31));
      t_bd    = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
